// File: rtl/player_mcu_pkg.sv
// player_mcu_pkg: shared music-player state encoding and song-index width default
package player_mcu_pkg;
  localparam int SONG_BITS_DEFAULT = 2;
  typedef enum logic [1:0] {
    PAUSED  = 2'd0,
    PLAYING = 2'd1,
    SKIP    = 2'd2,
    RESTART = 2'd3
  } state_e;
endpackage

// File: rtl/player_mcu.sv
// player_mcu: play/pause/skip/loop control FSM feeding the song reader
module player_mcu
  import player_mcu_pkg::*;
#(
  parameter int SONG_BITS = SONG_BITS_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 play_button,
  input  logic                 next_button,
  input  logic                 loop_mode,
  input  logic                 song_done,
  output logic                 play,
  output logic                 reset_player,
  output logic [SONG_BITS-1:0] song
);
  localparam logic [SONG_BITS-1:0] LAST_SONG = '1;
  state_e               state_q, state_d;
  logic [SONG_BITS-1:0] song_q, song_d;
  logic                 resume_q, resume_d;
  // next state, song advance on SKIP entry, and whether to resume playing after the skip
  always_comb begin
    state_d  = state_q;
    song_d   = song_q;
    resume_d = resume_q;
    case (state_q)
      PAUSED: begin
        if (next_button) begin
          state_d  = SKIP;
          song_d   = song_q + 1'b1;
          resume_d = 1'b0;
        end else if (play_button) begin
          state_d = PLAYING;
        end
      end
      PLAYING: begin
        if (next_button) begin
          state_d  = SKIP;
          song_d   = song_q + 1'b1;
          resume_d = 1'b1;
        end else if (song_done) begin
          state_d  = loop_mode ? RESTART : SKIP;
          song_d   = loop_mode ? song_q : song_q + 1'b1;
          resume_d = loop_mode ? resume_q : (song_q != LAST_SONG);
        end else if (play_button) begin
          state_d = PAUSED;
        end
      end
      SKIP:    state_d = resume_q ? PLAYING : PAUSED;
      default: state_d = PLAYING;
    endcase
  end
  // state, song and resume registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= PAUSED;
      song_q   <= '0;
      resume_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      song_q   <= song_d;
      resume_q <= resume_d;
    end
  end
  assign play         = (state_q == PLAYING);
  assign reset_player = (state_q == SKIP) || (state_q == RESTART);
  assign song         = song_q;
endmodule

// File: tb/tb_player_mcu.sv
// tb_player_mcu: directed-vector self-checking bench for player_mcu
module tb_player_mcu;
  import player_mcu_pkg::*;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       play_button = 1'b0;
  logic       next_button = 1'b0;
  logic       loop_mode = 1'b0;
  logic       song_done = 1'b0;
  logic       play;
  logic       reset_player;
  logic [1:0] song;
  int checks = 0;
  int errors = 0;

  player_mcu #(.SONG_BITS(2)) dut (
    .clk(clk), .reset(reset), .play_button(play_button), .next_button(next_button),
    .loop_mode(loop_mode), .song_done(song_done), .play(play),
    .reset_player(reset_player), .song(song)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input int pl, input int rp, input int sg);
    check({tag, ".play"}, int'(play), pl);
    check({tag, ".reset_player"}, int'(reset_player), rp);
    check({tag, ".song"}, int'(song), sg);
  endtask

  task automatic pulse(input logic r, input logic p, input logic n, input logic d);
    reset = r; play_button = p; next_button = n; song_done = d;
    @(posedge clk);
    #1;
    reset = 1'b0; play_button = 1'b0; next_button = 1'b0; song_done = 1'b0;
  endtask

  initial begin
    pulse(1, 0, 0, 0);
    pulse(1, 1, 1, 1);
    expect_out("reset", 0, 0, 0);
    pulse(0, 1, 0, 0); expect_out("play_on", 1, 0, 0);
    pulse(0, 1, 0, 0); expect_out("play_off", 0, 0, 0);
    pulse(0, 0, 0, 1); expect_out("paused_done_ignored", 0, 0, 0);
    pulse(0, 0, 1, 0); expect_out("pskip1", 0, 1, 1);
    pulse(0, 0, 0, 0); expect_out("pskip1_end", 0, 0, 1);
    pulse(0, 0, 1, 0); expect_out("pskip2", 0, 1, 2);
    pulse(0, 0, 0, 0); expect_out("pskip2_end", 0, 0, 2);
    pulse(0, 0, 1, 0); expect_out("pskip3", 0, 1, 3);
    pulse(0, 0, 0, 0); expect_out("pskip3_end", 0, 0, 3);
    pulse(0, 0, 1, 0); expect_out("wrap_skip", 0, 1, 0);
    pulse(0, 0, 0, 0); expect_out("wrap_end", 0, 0, 0);
    pulse(0, 1, 1, 0); expect_out("play_next_skip", 0, 1, 1);
    pulse(0, 0, 0, 0); expect_out("play_next_end", 0, 0, 1);
    pulse(0, 1, 0, 0); expect_out("play_s1", 1, 0, 1);
    pulse(0, 0, 0, 1); expect_out("done_skip", 0, 1, 2);
    pulse(0, 0, 0, 0); expect_out("done_resume", 1, 0, 2);
    pulse(0, 0, 1, 0); expect_out("next_play_skip", 0, 1, 3);
    pulse(0, 0, 0, 0); expect_out("next_play_resume", 1, 0, 3);
    pulse(0, 0, 0, 1); expect_out("album_end_skip", 0, 1, 0);
    pulse(0, 0, 0, 0); expect_out("album_end_stop", 0, 0, 0);
    pulse(0, 1, 0, 0); expect_out("replay", 1, 0, 0);
    pulse(0, 0, 1, 0); expect_out("to_s1", 0, 1, 1);
    pulse(0, 0, 0, 0); expect_out("to_s1_end", 1, 0, 1);
    pulse(0, 0, 1, 0); expect_out("to_s2", 0, 1, 2);
    pulse(0, 0, 0, 0); expect_out("to_s2_end", 1, 0, 2);
    loop_mode = 1'b1;
    pulse(0, 0, 0, 1); expect_out("loop_restart", 0, 1, 2);
    pulse(0, 0, 0, 0); expect_out("loop_resume", 1, 0, 2);
    loop_mode = 1'b0;
    pulse(0, 1, 1, 1); expect_out("all_three", 0, 1, 3);
    pulse(0, 1, 0, 0); expect_out("play_in_skip", 1, 0, 3);
    pulse(0, 0, 0, 0); expect_out("play_not_queued", 1, 0, 3);
    pulse(0, 0, 1, 0); expect_out("wrap_playing", 0, 1, 0);
    pulse(0, 0, 0, 1); expect_out("done_in_skip", 1, 0, 0);
    pulse(0, 0, 0, 0); expect_out("done_not_queued", 1, 0, 0);
    pulse(0, 0, 1, 0); expect_out("skip_before_reset", 0, 1, 1);
    pulse(1, 0, 0, 0); expect_out("reset_in_skip", 0, 0, 0);
    pulse(0, 0, 0, 0); expect_out("after_reset_skip", 0, 0, 0);
    pulse(0, 1, 0, 0); expect_out("play_again", 1, 0, 0);
    loop_mode = 1'b1;
    pulse(0, 0, 0, 1); expect_out("restart_before_reset", 0, 1, 0);
    pulse(1, 0, 0, 0); expect_out("reset_in_restart", 0, 0, 0);
    pulse(0, 0, 0, 0); expect_out("after_reset_restart", 0, 0, 0);
    loop_mode = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/player_mcu.md
PLAYER_MCU -- requirements
Module: player_mcu

Interface
REQ-001 Parameter SONG_BITS, default 2, width of the song index; song count = 2**SONG_BITS.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 play_button  input  1  one-cycle debounced pulse; toggles play/pause.
REQ-005 next_button  input  1  one-cycle debounced pulse; skip to next song.
REQ-006 loop_mode  input  1  level; 1 = repeat current song on song_done.
REQ-007 song_done  input  1  one-cycle pulse from song_reader: last note of current song finished.
REQ-008 play  output  1  to song_reader; 1 = advance through notes.
REQ-009 reset_player  output  1  to song_reader and note player; one-cycle restart pulse.
REQ-010 song  output  SONG_BITS  selected song index to song_reader.

Function
REQ-011 Four states: PAUSED, PLAYING, SKIP, RESTART; state register only, Moore outputs decoded from state and song register.
REQ-012 play SHALL be 1 exactly when state = PLAYING.
REQ-013 reset_player SHALL be 1 exactly when state = SKIP or RESTART.
REQ-014 song SHALL change only on the clock edge entering SKIP; held constant in all other states.
REQ-015 Input-to-output latency: an input sampled at edge n SHALL be reflected on outputs after edge n, with no further delay.
REQ-016 PAUSED: next_button -> SKIP (resume_flag <= 0); else play_button -> PLAYING; else stay; song_done ignored.
REQ-017 PLAYING, priority next_button > song_done > play_button: next_button -> SKIP (resume_flag <= 1); song_done with loop_mode=1 -> RESTART; song_done with loop_mode=0 -> SKIP; play_button alone -> PAUSED.
REQ-018 song_done in PLAYING with loop_mode=0 SHALL set resume_flag <= 1 unless song = 2**SONG_BITS-1; in that case resume_flag <= 0 (end-of-album stop).
REQ-019 SKIP SHALL last exactly one cycle: song <= song+1 mod 2**SONG_BITS on entry; exit to PLAYING if resume_flag=1, else PAUSED.
REQ-020 RESTART SHALL last exactly one cycle with song unchanged; exit to PLAYING.
REQ-021 All button and song_done inputs arriving during SKIP or RESTART SHALL be ignored (dropped, not queued).
REQ-022 Song index wrap: from 2**SONG_BITS-1, next_button SHALL go to 0 with no error indication.
REQ-023 Simultaneous play_button and next_button in PAUSED SHALL act as next_button only; the block ends in PAUSED.

Reset
REQ-024 While reset=1 at an edge: state <= PAUSED, song <= 0, resume_flag <= 0, regardless of other inputs.
REQ-025 After reset: play=0, reset_player=0, song=0.
REQ-026 Reset asserted during SKIP or RESTART SHALL abort the pulse; reset_player=0 after that edge.

Structure
REQ-027 State encoding localparams (PAUSED, PLAYING, SKIP, RESTART) and the SONG_BITS default SHALL be placed in the shared music-player package, so song_reader and the bench use the same values.
REQ-028 No sub-module; single FSM plus song counter and resume_flag registers, all within player_mcu.

Verification
REQ-029 Reset, then play_button pulse -> play=1 next cycle, song=0, reset_player=0; second pulse -> play=0.
REQ-030 Paused at song 3, next_button -> one cycle reset_player=1, song=0, play=0 throughout; ends in PAUSED.
REQ-031 Playing song 1, loop_mode=0, song_done -> one cycle SKIP (reset_player=1, song=2), then play=1.
REQ-032 Playing song 3, loop_mode=0, song_done -> song=0, one reset_player pulse, then play=0 (PAUSED).
REQ-033 Playing song 2, loop_mode=1, song_done -> reset_player=1 for one cycle, song stays 2, play=1 after.
REQ-034 Playing, next_button + song_done + play_button same cycle -> single skip (song+1), PLAYING after; play_button during SKIP cycle is ignored; reset during SKIP -> song=0, PAUSED.
